// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC owner, imem req/ack master, decode valid/ready source
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_addr              word read request to instruction memory (held until ack)
//   imem_ack/imem_rdata             one-cycle read completion with instruction word
//   redirect_valid/redirect_pc      one-cycle PC redirect (branch/jump target)
//   inst_valid/inst_ready           handshake towards instr_decoder
//   inst/inst_pc                    fetched instruction and its address
//   fetch_cnt                       count of completed decode handshakes (wrapping)

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'd3;

    // A request is outstanding in REQ and FLUSH. pc is never modified while in
    // FLUSH, so it still names the abandoned request and can drive the address.
    assign imem_req  = (state == REQ) || (state == FLUSH);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pending_pc <= 32'd0;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                    end
                    state <= REQ;
                end

                REQ: begin
                    if (redirect_valid && imem_ack) begin
                        // Returned word belongs to the stale path: drop it and
                        // issue the target fetch straight away.
                        pc <= redirect_tgt;
                    end else if (redirect_valid) begin
                        // Memory still owes us a word; wait it out in FLUSH.
                        pending_pc <= redirect_tgt;
                        state      <= FLUSH;
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        pc         <= pc + 32'd4;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + CNT_W'(1);
                    end
                    if (redirect_valid) begin
                        pc         <= redirect_tgt;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                FLUSH: begin
                    if (imem_ack) begin
                        pc    <= redirect_valid ? redirect_tgt : pending_pc;
                        state <= REQ;
                    end else if (redirect_valid) begin
                        pending_pc <= redirect_tgt;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (directed + randomized against a transaction model)

module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven before the call are seen at this edge,
    // outputs are sampled 1ns after it. Pulse inputs are cleared afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},  imem_addr,           RESET_PC);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},  inst,                32'd0);
        chk({tag, "_ipc"},   inst_pc,             32'd0);
        chk({tag, "_cnt"},   {16'd0, fetch_cnt},  32'd0);
    endtask

    logic [31:0] hold_inst, hold_pc, exp_pc, prev_addr, tgt;
    logic        prev_req, prev_ack, rdy, redir;
    int          cnt, waitc, delivered;

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();                                   // IDLE -> REQ
        chk("req_first",   {31'd0, imem_req}, 32'd1);
        chk("addr_first",  imem_addr, 32'h0040_0000);
        step();                                   // request waits one cycle
        chk("valid_before_ack", {31'd0, inst_valid}, 32'd0);
        chk("addr_stable_req",  imem_addr, 32'h0040_0000);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0040_0000);
        step();
        chk("valid_after_ack", {31'd0, inst_valid}, 32'd1);
        chk("inst0",           inst, mem_word(32'h0040_0000));
        chk("inst_pc0",        inst_pc, 32'h0040_0000);
        chk("req_in_hold",     {31'd0, imem_req}, 32'd0);

        // ---------------- stall in HOLD ----------------
        hold_inst = inst; hold_pc = inst_pc;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_inst",  inst, hold_inst);
            chk("stall_pc",    inst_pc, hold_pc);
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_cnt",   {16'd0, fetch_cnt}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("cnt_after_hs",  {16'd0, fetch_cnt}, 32'd1);
        chk("req_after_hs",  {31'd0, imem_req}, 32'd1);
        chk("addr_after_hs", imem_addr, 32'h0040_0004);

        // ---------------- redirect in REQ -> FLUSH ----------------
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("flush_req",  {31'd0, imem_req}, 32'd1);
            chk("flush_addr", imem_addr, 32'h0040_0004);
            if (i < 2) step();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("flush_next",  imem_addr, 32'h0040_0100);
        chk("flush_req2",  {31'd0, imem_req}, 32'd1);

        // ---------------- ack + redirect same cycle in REQ ----------------
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
        redirect_valid = 1'b1; redirect_pc = 32'h0050_0008;
        step();
        chk("ackred_valid", {31'd0, inst_valid}, 32'd0);
        chk("ackred_addr",  imem_addr, 32'h0050_0008);
        chk("ackred_req",   {31'd0, imem_req}, 32'd1);

        // ---------------- redirect in HOLD, with and without ready ----------------
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0050_0008);
        step();
        chk("hold2_pc", inst_pc, 32'h0050_0008);
        redirect_valid = 1'b1; redirect_pc = 32'h0060_0000; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("redir_rdy_cnt",   {16'd0, fetch_cnt}, 32'd2);
        chk("redir_rdy_addr",  imem_addr, 32'h0060_0000);
        chk("redir_rdy_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0060_0000);
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0070_0000;
        step();
        chk("redir_nrdy_cnt",   {16'd0, fetch_cnt}, 32'd2);
        chk("redir_nrdy_addr",  imem_addr, 32'h0070_0000);
        chk("redir_nrdy_valid", {31'd0, inst_valid}, 32'd0);

        // ---------------- PC wrap ----------------
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
        step();
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap_next", imem_addr, 32'h0000_0000);
        chk("wrap_cnt",  {16'd0, fetch_cnt}, 32'd3);

        // ---------------- reset mid-FLUSH ----------------
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        step();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_flush");
        step();
        step();
        chk_reset_outputs("rst_hold");
        rst_n = 1'b1;

        // ---------------- randomized run vs transaction model ----------------
        // Model: every decode handshake must deliver mem_word(expected pc); the
        // expected pc advances by 4 per delivery and jumps to the latest redirect.
        step();                                   // leave IDLE
        exp_pc = RESET_PC; cnt = 0; waitc = 1; delivered = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("rnd_cnt", {16'd0, fetch_cnt}, cnt[31:0] & 32'hFFFF);
            if (prev_req && !prev_ack && imem_req)
                chk("rnd_addr_stable", imem_addr, prev_addr);
            rdy   = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            if (inst_valid && rdy) begin
                chk("rnd_inst_pc", inst_pc, exp_pc);
                chk("rnd_inst",    inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                cnt++;
                delivered++;
            end
            if (redir) exp_pc = tgt & ~32'd3;
            inst_ready     = rdy;
            redirect_valid = redir;
            redirect_pc    = tgt;
            prev_req  = imem_req;
            prev_addr = imem_addr;
            if (imem_req) begin
                if (waitc == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    waitc      = $urandom_range(0, 3);
                end else begin
                    waitc--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                imem_ack   = 1'b1;                // stray ack must be ignored
                imem_rdata = 32'hBADD_A7A0;
            end
            prev_ack = imem_ack;
            step();
            inst_ready = 1'b0;
        end
        chk("rnd_progress", {31'd0, delivered > 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
